// File: rtl/waveform_renderer_pkg.sv
// Shared types and constants for the waveform renderer slice.
//   sample_t   : 12-bit acquisition sample (unsigned, mid-scale = 2048)
//   row_t      : 11-bit screen row
//   PLOT_*     : plot window geometry on screen
//   GRID_PITCH : graticule spacing (must be a power of two)
//   LATENCY    : pix_en cycles from hcount/vcount to every output
//   sat_shift  : clamps the vertical scale shift to MAX_SHIFT
package waveform_renderer_pkg;

    typedef logic [11:0] sample_t;
    typedef logic [10:0] row_t;

    localparam int PLOT_X0    = 128;
    localparam int PLOT_Y0    = 128;
    localparam int PLOT_W     = 768;
    localparam int PLOT_H     = 512;
    localparam int GRID_PITCH = 64;
    localparam int SAMPLE_MID = 2048;
    localparam int MAX_SHIFT  = 11;
    localparam int LATENCY    = 3;

    function automatic logic [3:0] sat_shift(input logic [3:0] s);
        return (s > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : s;
    endfunction

endpackage

// File: rtl/waveform_renderer_if.sv
// Bus between the video timing / sample RAM side and the renderer.
//   master : timing generator + RAM + acquisition (drives timing, cfg, dout)
//   slave  : renderer (drives r_addr and the per-pixel flags / delayed syncs)
// Transfer rule: there is no valid/ready pair. A pixel (hcount, vcount, syncs,
// active_in, frame_start) is taken on a rising clk edge only when pix_en is 1;
// when pix_en is 0 nothing moves anywhere. dout is combinational from r_addr.
interface waveform_renderer_if;
    import waveform_renderer_pkg::*;

    logic        pix_en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync_in;
    logic        vsync_in;
    logic        active_in;
    logic        frame_start;
    logic [3:0]  shift_cfg;
    logic [11:0] offset_cfg;
    sample_t     dout;
    sample_t     v_max;
    sample_t     v_min;
    logic [10:0] r_addr;
    logic        trace_on;
    logic        grid_on;
    logic        marker_on;
    logic        hsync_out;
    logic        vsync_out;
    logic        active_out;

    modport master (
        output pix_en, hcount, vcount, hsync_in, vsync_in, active_in, frame_start,
        output shift_cfg, offset_cfg, dout, v_max, v_min,
        input  r_addr, trace_on, grid_on, marker_on, hsync_out, vsync_out, active_out
    );

    modport slave (
        input  pix_en, hcount, vcount, hsync_in, vsync_in, active_in, frame_start,
        input  shift_cfg, offset_cfg, dout, v_max, v_min,
        output r_addr, trace_on, grid_on, marker_on, hsync_out, vsync_out, active_out
    );
endinterface

// File: rtl/waveform_renderer_sample_to_row.sv
// Combinational sample -> screen row conversion.
//   sample_i : 12-bit unsigned sample
//   shift_i  : vertical scale (arithmetic right shift), already saturated
//   offset_i : signed vertical offset in sample LSBs
//   row_o    : screen row, clamped to the plot window
// Larger samples sit higher on screen, hence the subtraction from the centre.
module waveform_renderer_sample_to_row
    import waveform_renderer_pkg::*;
(
    input  sample_t     sample_i,
    input  logic [3:0]  shift_i,
    input  logic [11:0] offset_i,
    output row_t        row_o
);
    localparam logic signed [13:0] MID    = 14'(SAMPLE_MID);
    localparam logic signed [13:0] CENTRE = 14'(PLOT_Y0 + PLOT_H / 2);
    localparam logic signed [13:0] ROW_LO = 14'(PLOT_Y0);
    localparam logic signed [13:0] ROW_HI = 14'(PLOT_Y0 + PLOT_H - 1);

    logic signed [13:0] centred;
    logic signed [13:0] scaled;
    logic signed [13:0] row_raw;

    always_comb begin
        // 14 bits covers -4096..4094 after offset and 384-scaled afterwards.
        centred = $signed({2'b00, sample_i}) - MID + $signed({{2{offset_i[11]}}, offset_i});
        scaled  = centred >>> shift_i;
        row_raw = CENTRE - scaled;
        if (row_raw < ROW_LO) begin
            row_o = row_t'(ROW_LO);
        end else if (row_raw > ROW_HI) begin
            row_o = row_t'(ROW_HI);
        end else begin
            row_o = row_raw[10:0];
        end
    end
endmodule

// File: rtl/waveform_renderer.sv
// On-the-fly oscilloscope trace renderer, three pix_en-qualified stages:
//   S0: decode hcount/vcount, register RAM address and window/grid flags
//   S1: convert RAM data (and v_max/v_min) to screen rows
//   S2: vertical fill against the previous column, register output flags
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : waveform_renderer_if.slave (timing in, cfg, RAM, flags/syncs out)
module waveform_renderer
    import waveform_renderer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    waveform_renderer_if.slave bus
);
    localparam logic [10:0] X_FIRST  = 11'(PLOT_X0);
    localparam logic [10:0] X_END    = 11'(PLOT_X0 + PLOT_W);
    localparam logic [10:0] Y_FIRST  = 11'(PLOT_Y0);
    localparam logic [10:0] Y_END    = 11'(PLOT_Y0 + PLOT_H);
    localparam logic [10:0] COL_LAST = 11'(PLOT_W - 1);
    localparam logic [10:0] ROW_LAST = 11'(PLOT_H - 1);
    localparam logic [10:0] PITCH_M  = 11'(GRID_PITCH - 1);
    localparam row_t        CENTRE   = row_t'(PLOT_Y0 + PLOT_H / 2);

    // S0 decode
    logic [10:0] col, yoff;
    logic        col_ok, row_ok, x_grid, y_grid;

    always_comb begin
        col    = bus.hcount - X_FIRST;
        yoff   = bus.vcount - Y_FIRST;
        col_ok = (bus.hcount >= X_FIRST) && (bus.hcount < X_END);
        row_ok = (bus.vcount >= Y_FIRST) && (bus.vcount < Y_END);
        // Border column/row on the far side is not on the pitch, add it explicitly.
        x_grid = ((col & PITCH_M) == 11'd0) || (col == COL_LAST);
        y_grid = ((yoff & PITCH_M) == 11'd0) || (yoff == ROW_LAST);
    end

    // Pipeline and configuration state
    logic [10:0]        r_addr_q;
    logic               plot0_q, col0_0_q, grid0_q;
    row_t               vcnt0_q;
    logic [LATENCY-1:0] hs_q, vs_q, act_q;
    logic               fs0_q;
    logic [3:0]         pend_shift_q, shift_q;
    logic [11:0]        pend_off_q, off_q;
    sample_t            pend_vmax_q, pend_vmin_q, vmax_q, vmin_q;
    row_t               row1_q, vcnt1_q, max_row1_q, min_row1_q;
    logic               plot1_q, col0_1_q, grid1_q;
    row_t               prev_row_q;
    logic               trace_q, grid_q, marker_q;

    // S1 conversions, all from the live shadows
    row_t trace_row, max_row, min_row;

    waveform_renderer_sample_to_row u_trace (
        .sample_i (bus.dout), .shift_i (shift_q), .offset_i (off_q), .row_o (trace_row)
    );
    waveform_renderer_sample_to_row u_vmax (
        .sample_i (vmax_q), .shift_i (shift_q), .offset_i (off_q), .row_o (max_row)
    );
    waveform_renderer_sample_to_row u_vmin (
        .sample_i (vmin_q), .shift_i (shift_q), .offset_i (off_q), .row_o (min_row)
    );

    // S2 fill window: column 0 uses its own row so no line joins across scanlines.
    row_t prev_sel, lo_row, hi_row;
    logic vis, trace_d, grid_d, marker_d;

    always_comb begin
        prev_sel = col0_1_q ? row1_q : prev_row_q;
        lo_row   = (prev_sel < row1_q) ? prev_sel : row1_q;
        hi_row   = (prev_sel < row1_q) ? row1_q : prev_sel;
        vis      = plot1_q && act_q[1];
        trace_d  = vis && (vcnt1_q >= lo_row) && (vcnt1_q <= hi_row);
        grid_d   = vis && grid1_q;
        marker_d = vis && ((vcnt1_q == max_row1_q) || (vcnt1_q == min_row1_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_q     <= '0;
            plot0_q      <= 1'b0;
            col0_0_q     <= 1'b0;
            grid0_q      <= 1'b0;
            vcnt0_q      <= '0;
            hs_q         <= '0;
            vs_q         <= '0;
            act_q        <= '0;
            fs0_q        <= 1'b0;
            pend_shift_q <= 4'd3;
            pend_off_q   <= '0;
            pend_vmax_q  <= sample_t'(SAMPLE_MID);
            pend_vmin_q  <= sample_t'(SAMPLE_MID);
            shift_q      <= 4'd3;
            off_q        <= '0;
            vmax_q       <= sample_t'(SAMPLE_MID);
            vmin_q       <= sample_t'(SAMPLE_MID);
            row1_q       <= CENTRE;
            vcnt1_q      <= '0;
            max_row1_q   <= CENTRE;
            min_row1_q   <= CENTRE;
            plot1_q      <= 1'b0;
            col0_1_q     <= 1'b0;
            grid1_q      <= 1'b0;
            prev_row_q   <= CENTRE;
            trace_q      <= 1'b0;
            grid_q       <= 1'b0;
            marker_q     <= 1'b0;
        end else if (bus.pix_en) begin
            // S0
            r_addr_q <= col_ok ? col : 11'd0;
            plot0_q  <= col_ok && row_ok;
            col0_0_q <= col_ok && (col == 11'd0);
            grid0_q  <= x_grid || y_grid;
            vcnt0_q  <= bus.vcount;
            hs_q     <= {hs_q[LATENCY-2:0], bus.hsync_in};
            vs_q     <= {vs_q[LATENCY-2:0], bus.vsync_in};
            act_q    <= {act_q[LATENCY-2:0], bus.active_in};
            // Cfg is captured with the frame_start pixel but only lands in the
            // shadows one stage later, so that pixel still converts with the old
            // cfg and the very next pixel sees the new one.
            fs0_q <= bus.frame_start;
            if (bus.frame_start) begin
                pend_shift_q <= sat_shift(bus.shift_cfg);
                pend_off_q   <= bus.offset_cfg;
                pend_vmax_q  <= bus.v_max;
                pend_vmin_q  <= bus.v_min;
            end
            if (fs0_q) begin
                shift_q <= pend_shift_q;
                off_q   <= pend_off_q;
                vmax_q  <= pend_vmax_q;
                vmin_q  <= pend_vmin_q;
            end
            // S1 (marker rows travel with the pixel so cfg switches stay aligned)
            row1_q     <= trace_row;
            vcnt1_q    <= vcnt0_q;
            max_row1_q <= max_row;
            min_row1_q <= min_row;
            plot1_q    <= plot0_q;
            col0_1_q   <= col0_0_q;
            grid1_q    <= grid0_q;
            // S2
            prev_row_q <= row1_q;
            trace_q    <= trace_d;
            grid_q     <= grid_d;
            marker_q   <= marker_d;
        end
    end

    assign bus.r_addr     = r_addr_q;
    assign bus.trace_on   = trace_q;
    assign bus.grid_on    = grid_q;
    assign bus.marker_on  = marker_q;
    assign bus.hsync_out  = hs_q[LATENCY-1];
    assign bus.vsync_out  = vs_q[LATENCY-1];
    assign bus.active_out = act_q[LATENCY-1];
endmodule

// File: tb/tb_waveform_renderer.sv
`timescale 1ns/1ps
module tb_waveform_renderer;
    import waveform_renderer_pkg::*;

    // Expected word: {h[10:0], v[10:0], trace, grid, marker, hsync, vsync, active}
    localparam int W = 28;

    logic clk = 1'b0;
    logic reset;

    waveform_renderer_if vif();

    waveform_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    sample_t ram [PLOT_W];
    always_comb vif.dout = (vif.r_addr < 11'(PLOT_W)) ? ram[vif.r_addr] : 12'd0;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    logic [10:0]  last_raddr;
    int          pe_mode;

    // Reference model state: the cfg currently in force and the row drawn
    // for the previous column of this scanline.
    int m_shift, m_off, m_vmax, m_vmin;
    int last_row;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int row_of(input int s);
        int v, d, q;
        v = s - SAMPLE_MID + m_off;
        d = 1 << m_shift;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);   // floor division
        q = (PLOT_Y0 + PLOT_H / 2) - q;
        if (q < PLOT_Y0) q = PLOT_Y0;
        if (q > PLOT_Y0 + PLOT_H - 1) q = PLOT_Y0 + PLOT_H - 1;
        return q;
    endfunction

    task automatic check_outputs(input string kind, input logic [W-1:0] e);
        string at;
        at = $sformatf("%s h=%0d v=%0d", kind, e[27:17], e[16:6]);
        check_eq({at, " trace"},  16'(vif.trace_on),   16'(e[5]));
        check_eq({at, " grid"},   16'(vif.grid_on),    16'(e[4]));
        check_eq({at, " marker"}, 16'(vif.marker_on),  16'(e[3]));
        check_eq({at, " hsync"},  16'(vif.hsync_out),  16'(e[2]));
        check_eq({at, " vsync"},  16'(vif.vsync_out),  16'(e[1]));
        check_eq({at, " active"}, 16'(vif.active_out), 16'(e[0]));
    endtask

    task automatic model_defaults();
        m_shift = 3; m_off = 0; m_vmax = SAMPLE_MID; m_vmin = SAMPLE_MID;
        last_row = PLOT_Y0 + PLOT_H / 2;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        last_exp = '0;
        last_raddr = '0;
    endtask

    // Present one pixel, wait until it is taken, then score.
    task automatic present(input int h, input int v, input bit fs);
        logic [W-1:0] e, e_old;
        int col, r, prev, lo, hi, stalls, exp_addr;
        bit col_ok, vis, tr, gr, mk, hs, vs, act, pe;
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        act = ($urandom_range(0, 7) != 0);
        vif.hcount = 11'(h); vif.vcount = 11'(v);
        vif.hsync_in = hs; vif.vsync_in = vs; vif.active_in = act;
        vif.frame_start = fs;

        col    = h - PLOT_X0;
        col_ok = (col >= 0) && (col < PLOT_W);
        vis    = col_ok && (v >= PLOT_Y0) && (v < PLOT_Y0 + PLOT_H) && act;
        r      = col_ok ? row_of(int'(ram[col])) : 0;
        prev   = (col == 0) ? r : last_row;
        if (col_ok) last_row = r;
        lo = (prev < r) ? prev : r;
        hi = (prev < r) ? r : prev;
        tr = vis && (v >= lo) && (v <= hi);
        gr = vis && ((col % GRID_PITCH) == 0 || col == PLOT_W - 1 ||
                     ((v - PLOT_Y0) % GRID_PITCH) == 0 || v == PLOT_Y0 + PLOT_H - 1);
        mk = vis && (v == row_of(m_vmax) || v == row_of(m_vmin));
        e  = {11'(h), 11'(v), tr, gr, mk, hs, vs, act};
        exp_addr = col_ok ? col : 0;
        if (fs) begin
            m_shift = (int'(vif.shift_cfg) > MAX_SHIFT) ? MAX_SHIFT : int'(vif.shift_cfg);
            m_off   = int'($signed(vif.offset_cfg));
            m_vmax  = int'(vif.v_max);
            m_vmin  = int'(vif.v_min);
        end

        stalls = 0;
        do begin
            pe = (pe_mode == 0 || stalls >= 8) ? 1'b1 : ($urandom_range(0, 3) == 0);
            vif.pix_en = pe;
            @(posedge clk); #1;
            if (!pe) begin
                stalls++;
                check_outputs("hold", last_exp);
                check_eq("hold r_addr", 16'(vif.r_addr), 16'(last_raddr));
            end
        end while (!pe);

        check_eq($sformatf("r_addr h=%0d", h), 16'(vif.r_addr), 16'(exp_addr));
        last_raddr = 11'(exp_addr);
        exp_q.push_back(e);
        if (exp_q.size() >= LATENCY) begin
            e_old = exp_q.pop_front();
            check_outputs("pix", e_old);
            last_exp = e_old;
        end
    endtask

    task automatic scan_line(input int v, input int h0, input int h1, input int fs_h);
        for (int h = h0; h <= h1; h++) present(h, v, h == fs_h);
    endtask

    task automatic flush();
        for (int i = 0; i < LATENCY; i++) present(1000, 0, 1'b0);
    endtask

    // mode 0: constant, 1: step at col 100, 2: uniform random, 3: ramp
    task automatic load_ram(input int mode, input int val);
        flush();
        for (int i = 0; i < PLOT_W; i++) begin
            case (mode)
                0:       ram[i] = 12'(val);
                1:       ram[i] = (i < 100) ? 12'd2048 : 12'd4095;
                2:       ram[i] = 12'($urandom_range(0, 4095));
                default: ram[i] = 12'((i * 5) % 4096);
            endcase
        end
    endtask

    task automatic apply_cfg(input int sh, input int off, input int vmax, input int vmin);
        vif.shift_cfg = 4'(sh); vif.offset_cfg = 12'(off);
        vif.v_max = 12'(vmax); vif.v_min = 12'(vmin);
        present(1000, 0, 1'b1);
    endtask

    task automatic mid_reset();
        vif.pix_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outputs("reset", '0);
        check_eq("reset r_addr", 16'(vif.r_addr), 16'd0);
        @(posedge clk); #1;
        check_outputs("reset_held", '0);
        @(negedge clk);
        reset = 1'b1;
        model_defaults();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        pe_mode = 0;
        vif.pix_en = 1'b0; vif.hcount = '0; vif.vcount = '0;
        vif.hsync_in = 1'b0; vif.vsync_in = 1'b0; vif.active_in = 1'b0;
        vif.frame_start = 1'b0;
        vif.shift_cfg = 4'd3; vif.offset_cfg = '0;
        vif.v_max = 12'd2048; vif.v_min = 12'd2048;
        for (int i = 0; i < PLOT_W; i++) ram[i] = 12'd2048;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("por", '0);
        check_eq("por r_addr", 16'(vif.r_addr), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        model_defaults();
        @(posedge clk); #1;

        // Flat mid-scale trace, default cfg
        load_ram(0, 2048);
        scan_line(384, 126, 899, -1);
        scan_line(383, 127, 899, -1);
        scan_line(200, 120, 400, -1);

        // Full-scale and zero samples, clamp at the bottom border
        load_ram(0, 4095);
        scan_line(129, 127, 899, -1);
        scan_line(130, 127, 500, -1);
        load_ram(0, 0);
        scan_line(639, 127, 899, -1);
        scan_line(640, 127, 300, -1);

        // Step at column 100: vertical fill between adjacent columns
        load_ram(1, 0);
        scan_line(129, 120, 300, -1);
        scan_line(250, 120, 300, -1);
        scan_line(384, 120, 300, -1);
        scan_line(385, 120, 300, -1);
        scan_line(128, 120, 300, -1);

        // Random data with random cfg changes at random pixels
        for (int k = 0; k < 6; k++) begin
            load_ram(2, 0);
            vif.shift_cfg  = 4'($urandom_range(0, 15));
            vif.offset_cfg = 12'($urandom_range(0, 4095));
            vif.v_max      = 12'($urandom_range(0, 4095));
            vif.v_min      = 12'($urandom_range(0, 4095));
            begin
                int v, he;
                v  = $urandom_range(120, 645);
                he = $urandom_range(200, 899);
                scan_line(v, 127, he, $urandom_range(127, he));
            end
        end

        // Mid-frame cfg change ignored until frame_start; shift 15 saturates
        load_ram(3, 0);
        apply_cfg(3, 0, 2048, 2048);
        vif.shift_cfg = 4'd0;
        scan_line(384, 127, 899, -1);
        vif.shift_cfg = 4'd15;
        scan_line(300, 127, 899, 895);   // frame_start on the last plot pixel
        scan_line(384, 127, 899, -1);
        scan_line(385, 127, 600, -1);

        // Markers and graticule
        vif.shift_cfg = 4'd3; vif.offset_cfg = '0;
        vif.v_max = 12'd3072; vif.v_min = 12'd1024;
        scan_line(256, 127, 899, 895);
        scan_line(256, 127, 899, -1);
        scan_line(512, 127, 899, -1);
        scan_line(192, 127, 899, -1);
        scan_line(639, 127, 899, -1);

        // Sparse pix_en with a reset in the middle of a line
        pe_mode = 1;
        load_ram(2, 0);
        scan_line(300, 120, 350, -1);
        scan_line(400, 120, 250, -1);
        mid_reset();
        scan_line(384, 120, 350, -1);
        scan_line(200, 120, 300, -1);
        apply_cfg($urandom_range(0, 15), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
        for (int k = 0; k < 3; k++) scan_line($urandom_range(128, 639), 120, 330, -1);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
